stream_pool2x2: RTL and testbench
=================================

// Module: stream_pool2x2
// PURPOSE
//  Builds the level-(LEVEL+1) stream feeding stream_patch (LEVEL+1).
//  Takes the level-LEVEL stream: one valid pixel every 2^LEVEL clocks in each direction, marked by in_enable.
//  Averages each 2x2 block of valid pixels into one rounded output pixel.
//  Output keeps full-resolution frame coordinates, so the downstream coord/LEVEL masks apply unchanged.
// PARAMETERS
//  BIT_WIDTH     -1   pixel bit width (>=1)
//  IMAGE_HEIGHT  -1   active image rows (full res); divisible by 2^(LEVEL+1)
//  IMAGE_WIDTH   -1   active image cols (full res); divisible by 2^(LEVEL+1)
//  FRAME_HEIGHT  -1   frame rows incl. sync
//  FRAME_WIDTH   -1   frame cols incl. sync
//  LEVEL          0   input pyramid level (0..3); output is level LEVEL+1
// PORTS
//  clock      in   1          system clock, all logic on rising edge
//  n_rst      in   1          synchronous reset, active low
//  in_enable  in   1          input pixel valid strobe
//  in_pixel   in   BIT_WIDTH  input pixel
//  in_vcnt    in   9          full-res row counter, log2(480)
//  in_hcnt    in   10         full-res col counter, log2(640)
//  out_pixel  out  BIT_WIDTH  averaged pixel
//  out_vcnt   out  9          in_vcnt delayed 2 clocks
//  out_hcnt   out  10         in_hcnt delayed 2 clocks
//  out_enable out  1          1-clock strobe: out_pixel holds a new level-(LEVEL+1) pixel
// BEHAVIOUR
//  - Accepted input: in_enable=1 and in_vcnt<IMAGE_HEIGHT and in_hcnt<IMAGE_WIDTH; all other cycles ignored.
//  - Parity bits: hp = in_hcnt[LEVEL], vp = in_vcnt[LEVEL]; column index col = in_hcnt>>(LEVEL+1).
//  - Horizontal pair:
//    - accepted with hp=0: h_hold <= in_pixel.
//    - accepted with hp=1: psum = h_hold + in_pixel, width BIT_WIDTH+1.
//  - Line buffer: depth IMAGE_WIDTH>>(LEVEL+1), width BIT_WIDTH+1; synchronous read, 1-clock read latency.
//    - vp=0, hp=1: write psum at col; set lb_primed when col==0.
//    - vp=1, hp=1: read col.
//  - Pipeline, stage 1 (clock after the vp=1,hp=1 accept): register psum and the fetched line-buffer word.
//  - Pipeline, stage 2: sum4 = lb + psum (BIT_WIDTH+2 bits); out_pixel <= (sum4+2)>>2.
//    - Max (4*(2^B-1)+2)>>2 = 2^B-1, so no saturation is needed.
//  - out_enable=1 exactly 2 clocks after each accepted vp=1,hp=1 pixel, only if lb_primed=1.
//  - out_pixel holds its last value between strobes.
//  - out_vcnt/out_hcnt: free-running 2-stage delay of in_vcnt/in_hcnt, independent of in_enable.
//    - At a strobe they equal the coords of the bottom-right pixel of the 2x2 block.
//  - Reset (n_rst=0 at an edge):
//    - out_pixel=0, out_vcnt=0, out_hcnt=0, out_enable=0.
//    - h_hold=0, pipeline valid bits=0, lb_primed=0.
//    - Line buffer RAM is not reset.
//  - Reset mid-frame: no strobe until a vp=0 row rewrites col 0, so stale RAM is never output.
//    - Pipeline contents in flight at reset are discarded.
//  - A second accept with hp=1 without an intervening hp=0 accept reuses h_hold; no error flag.
//  - Frame wrap (vcnt back to 0): no special action; row parity restarts the pairing.
//  - Gaps in in_enable (stall) only delay pairing; state is held.
// TESTING
//  1. B=8, LEVEL=0, 8x4 image, ramp pixel=h+8v -> strobes at (v,h)=(1,1),(1,3)..;
//     (1,1) out_pixel=(0+1+8+9+2)>>2=5.
//  2. Constant 255 everywhere -> every strobe out_pixel=255 (no overflow); constant 0 -> 0.
//  3. Rounding: block {1,0,0,1} -> sum 2 -> out 1; block {1,0,0,0} -> out 0.
//  4. LEVEL=1, in_enable only when vcnt[0]&hcnt[0] -> strobes only where vcnt[1:0]==3 and hcnt[1:0]==3;
//     averages use level-1 pixels.
//  5. Reset asserted during row 1 of frame -> out_enable=0 until after the next even row.
//     First strobe then uses the fresh row; out_vcnt/out_hcnt=0 the clock after reset.
//  6. Blank region (hcnt>=IMAGE_WIDTH, vcnt>=IMAGE_HEIGHT) with in_enable=1, random pixels ->
//     no strobe, line buffer unchanged.

Source files
------------

// File: rtl/stream_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pool2x2
//  Description : 2x2 average-pooling stage for a pixel-pyramid stream.
//                Takes a level-LEVEL stream (one valid pixel every 2^LEVEL
//                clocks in each direction) and emits one rounded average
//                per 2x2 block of valid pixels, i.e. a level-(LEVEL+1)
//                stream. Output coordinates stay in full-resolution frame
//                units, so downstream coordinate masks apply unchanged.
//  Ports       :
//    clock      in   1          system clock, rising edge
//    n_rst      in   1          synchronous reset, active low
//    in_enable  in   1          input pixel valid strobe
//    in_pixel   in   BIT_WIDTH  input pixel
//    in_vcnt    in   9          full-res row counter
//    in_hcnt    in   10         full-res column counter
//    out_pixel  out  BIT_WIDTH  averaged pixel (held between strobes)
//    out_vcnt   out  9          in_vcnt delayed by 2 clocks
//    out_hcnt   out  10         in_hcnt delayed by 2 clocks
//    out_enable out  1          one-clock strobe: new out_pixel available
//  Revision    : 1.0  initial release
// ============================================================================
module stream_pool2x2 #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 525,
    parameter int FRAME_WIDTH  = 800,
    parameter int LEVEL        = 0
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 in_enable,
    input  logic [BIT_WIDTH-1:0] in_pixel,
    input  logic [8:0]           in_vcnt,
    input  logic [9:0]           in_hcnt,
    output logic [BIT_WIDTH-1:0] out_pixel,
    output logic [8:0]           out_vcnt,
    output logic [9:0]           out_hcnt,
    output logic                 out_enable
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_PSUM_W   = BIT_WIDTH + 1;   // sum of two pixels
    localparam int c_SUM4_W   = BIT_WIDTH + 2;   // sum of four pixels
    localparam int c_LB_DEPTH = IMAGE_WIDTH >> (LEVEL + 1);
    localparam int c_COL_W    = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;

    // Active-area limits. The image is never larger than the frame; clipping
    // to the frame keeps a misconfigured instance from accepting sync area.
    localparam int c_V_LIM_I  = (IMAGE_HEIGHT < FRAME_HEIGHT) ? IMAGE_HEIGHT : FRAME_HEIGHT;
    localparam int c_H_LIM_I  = (IMAGE_WIDTH  < FRAME_WIDTH)  ? IMAGE_WIDTH  : FRAME_WIDTH;
    // One extra bit so a limit equal to 2^N still compares correctly.
    localparam logic [9:0]  c_V_LIMIT = 10'(c_V_LIM_I);
    localparam logic [10:0] c_H_LIMIT = 11'(c_H_LIM_I);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                 w_accept;     // pixel is valid and inside image
    logic                 w_hp;         // odd column of the current level
    logic                 w_vp;         // odd row of the current level
    logic [c_COL_W-1:0]   w_col;        // pooled column index
    logic [c_PSUM_W-1:0]  w_psum;       // horizontal pair sum
    logic                 w_lb_wr;      // store pair sum (top row of block)
    logic                 w_lb_rd;      // fetch pair sum (bottom row of block)
    logic [c_SUM4_W-1:0]  w_sum4;
    logic [BIT_WIDTH-1:0] w_avg;

    logic [BIT_WIDTH-1:0] r_h_hold;     // left pixel of the horizontal pair
    logic                 r_lb_primed;  // line buffer holds a post-reset row
    logic                 r_s1_valid;   // stage-1 holds a block to emit
    logic [c_PSUM_W-1:0]  r_s1_psum;    // bottom-row pair sum, stage 1
    logic [c_PSUM_W-1:0]  r_lb_rd;      // top-row pair sum read from RAM
    logic [8:0]           r_vcnt_d1;
    logic [9:0]           r_hcnt_d1;

    logic [c_PSUM_W-1:0]  r_lb_mem [c_LB_DEPTH];

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = in_enable
                   && ({1'b0, in_vcnt} < c_V_LIMIT)
                   && ({1'b0, in_hcnt} < c_H_LIMIT);
        w_hp     = in_hcnt[LEVEL];
        w_vp     = in_vcnt[LEVEL];
        w_col    = c_COL_W'(in_hcnt >> (LEVEL + 1));
        w_psum   = {1'b0, r_h_hold} + {1'b0, in_pixel};
        // Inputs presented while reset is asserted are ignored entirely.
        w_lb_wr  = n_rst && w_accept && w_hp && !w_vp;
        w_lb_rd  = n_rst && w_accept && w_hp &&  w_vp;
    end

    // ------------------------------------------------------------------
    // Line buffer: one pair sum per pooled column, synchronous read.
    // Contents are deliberately not reset; r_lb_primed guards stale data.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_lb_wr) begin
            r_lb_mem[w_col] <= w_psum;
        end
        if (w_lb_rd) begin
            r_lb_rd <= r_lb_mem[w_col];
        end
    end

    // ------------------------------------------------------------------
    // Final average with round-half-up. The maximum result equals the
    // maximum pixel value, so the top bits never need saturating.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum4 = c_SUM4_W'(r_lb_rd) + c_SUM4_W'(r_s1_psum) + c_SUM4_W'(2);
        w_avg  = w_sum4[c_SUM4_W-1:2];
    end

    // ------------------------------------------------------------------
    // Control, pipeline and coordinate delay
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_h_hold    <= '0;
            r_lb_primed <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_psum   <= '0;
            r_vcnt_d1   <= '0;
            r_hcnt_d1   <= '0;
            out_vcnt    <= '0;
            out_hcnt    <= '0;
            out_pixel   <= '0;
            out_enable  <= 1'b0;
        end else begin
            // Coordinates are delayed unconditionally so they line up with
            // the two-clock pixel latency.
            r_vcnt_d1 <= in_vcnt;
            r_hcnt_d1 <= in_hcnt;
            out_vcnt  <= r_vcnt_d1;
            out_hcnt  <= r_hcnt_d1;

            if (w_accept && !w_hp) begin
                r_h_hold <= in_pixel;
            end

            // Column 0 of a top row is the first write of a fresh row, so
            // every later read in the following bottom row sees live data.
            if (w_lb_wr && (w_col == '0)) begin
                r_lb_primed <= 1'b1;
            end

            // Stage 1: capture the bottom-row pair alongside the RAM read.
            r_s1_valid <= w_lb_rd && r_lb_primed;
            if (w_lb_rd) begin
                r_s1_psum <= w_psum;
            end

            // Stage 2: emit the average; hold the pixel otherwise.
            out_enable <= r_s1_valid;
            if (r_s1_valid) begin
                out_pixel <= w_avg;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_pool2x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_pool2x2
//  Description : Self-checking bench for stream_pool2x2. Two instances run
//                side by side (LEVEL=0 and LEVEL=1) on a small 8x4 image in
//                a 10x6 frame. Expected outputs come from an image-level
//                reference: every accepted pixel is stored in a frame array
//                and a strobe's value is the rounded mean of the 2x2 block
//                whose bottom-right corner is the current pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_pool2x2;

    localparam int c_IH = 4;
    localparam int c_IW = 8;
    localparam int c_FH = 6;
    localparam int c_FW = 10;

    localparam int c_M_RAMP  = 0;
    localparam int c_M_FF    = 1;
    localparam int c_M_ZERO  = 2;
    localparam int c_M_ROUND = 3;
    localparam int c_M_RAND  = 4;

    logic       clock = 1'b0;
    logic       n_rst;
    logic       in_enable0, in_enable1;
    logic [7:0] in_pixel;
    logic [8:0] in_vcnt;
    logic [9:0] in_hcnt;

    logic [7:0] out_pixel0, out_pixel1;
    logic [8:0] out_vcnt0,  out_vcnt1;
    logic [9:0] out_hcnt0,  out_hcnt1;
    logic       out_enable0, out_enable1;

    int total = 0;
    int bad   = 0;

    // Reference state
    int img [2][c_FH][c_FW];
    int e_en [2];
    int e_pix[2];
    int s1v  [2];
    int s1p  [2];
    int primed[2];
    int e_v, e_h, d1v, d1h;

    always #5 clock = ~clock;

    stream_pool2x2 #(
        .BIT_WIDTH(8), .IMAGE_HEIGHT(c_IH), .IMAGE_WIDTH(c_IW),
        .FRAME_HEIGHT(c_FH), .FRAME_WIDTH(c_FW), .LEVEL(0)
    ) u_dut0 (
        .clock(clock), .n_rst(n_rst), .in_enable(in_enable0),
        .in_pixel(in_pixel), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_pixel(out_pixel0), .out_vcnt(out_vcnt0), .out_hcnt(out_hcnt0),
        .out_enable(out_enable0)
    );

    stream_pool2x2 #(
        .BIT_WIDTH(8), .IMAGE_HEIGHT(c_IH), .IMAGE_WIDTH(c_IW),
        .FRAME_HEIGHT(c_FH), .FRAME_WIDTH(c_FW), .LEVEL(1)
    ) u_dut1 (
        .clock(clock), .n_rst(n_rst), .in_enable(in_enable1),
        .in_pixel(in_pixel), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_pixel(out_pixel1), .out_vcnt(out_vcnt1), .out_hcnt(out_hcnt1),
        .out_enable(out_enable1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rounded mean of the 2x2 block ending at (v,h) for level d.
    function automatic int block_avg(input int d, input int v, input int h);
        int s;
        s = 1 << d;
        return (img[d][v-s][h-s] + img[d][v-s][h] + img[d][v][h-s] + img[d][v][h] + 2) / 4;
    endfunction

    task automatic model_edge(input bit rstn, input bit en0, input bit en1,
                              input int pix, input int v, input int h);
        bit en, acc;
        for (int d = 0; d < 2; d++) begin
            en = (d == 0) ? en0 : en1;
            if (!rstn) begin
                e_en[d] = 0; e_pix[d] = 0; s1v[d] = 0; primed[d] = 0;
            end else begin
                e_en[d] = s1v[d];
                if (s1v[d] != 0) e_pix[d] = s1p[d];
                s1v[d] = 0;
                acc = en && (v < c_IH) && (h < c_IW);
                if (acc) begin
                    img[d][v][h] = pix;
                    if ((((v >> d) & 1) == 1) && (((h >> d) & 1) == 1)) begin
                        s1v[d] = primed[d];
                        s1p[d] = block_avg(d, v, h);
                    end
                    if ((((v >> d) & 1) == 0) && ((h >> d) == 1)) primed[d] = 1;
                end
            end
        end
        if (!rstn) begin
            e_v = 0; e_h = 0; d1v = 0; d1h = 0;
        end else begin
            e_v = d1v; e_h = d1h; d1v = v; d1h = h;
        end
    endtask

    task automatic check_all();
        chk("en0",  32'(out_enable0), 32'(e_en[0]));
        chk("pix0", 32'(out_pixel0),  32'(e_pix[0]));
        chk("vcnt0", 32'(out_vcnt0),  32'(e_v));
        chk("hcnt0", 32'(out_hcnt0),  32'(e_h));
        chk("en1",  32'(out_enable1), 32'(e_en[1]));
        chk("pix1", 32'(out_pixel1),  32'(e_pix[1]));
        chk("vcnt1", 32'(out_vcnt1),  32'(e_v));
        chk("hcnt1", 32'(out_hcnt1),  32'(e_h));
    endtask

    task automatic step(input bit rstn, input bit en0, input bit en1,
                        input logic [7:0] pix, input int v, input int h);
        n_rst      = rstn;
        in_enable0 = en0;
        in_enable1 = en1;
        in_pixel   = pix;
        in_vcnt    = 9'(v);
        in_hcnt    = 10'(h);
        @(posedge clock);
        model_edge(rstn, en0, en1, int'(pix), v, h);
        #1;
        check_all();
    endtask

    function automatic logic [7:0] pattern(input int mode, input int v, input int h);
        case (mode)
            c_M_RAMP:  return 8'(h + 8 * v);
            c_M_FF:    return 8'd255;
            c_M_ZERO:  return 8'd0;
            c_M_ROUND: return (((v % 2 == 0) && (h % 2 == 0)) || ((v % 2 == 1) && (h % 4 == 1)))
                              ? 8'd1 : 8'd0;
            default:   return 8'($urandom);
        endcase
    endfunction

    // Directed values at the first two level-1 strobes of row 1.
    function automatic int first_strobe(input int mode, input int which);
        case (mode)
            c_M_RAMP:  return (which == 0) ? 5 : 7;
            c_M_FF:    return 255;
            c_M_ROUND: return (which == 0) ? 1 : 0;
            default:   return 0;
        endcase
    endfunction

    // One full frame scan. Optional random stall cycles; optional reset
    // held for two clocks starting at (rst_v, rst_h).
    task automatic frame(input int mode, input bit gaps, input int rst_v, input int rst_h);
        bit rstn;
        for (int v = 0; v < c_FH; v++) begin
            for (int h = 0; h < c_FW; h++) begin
                if (gaps && ($urandom_range(3) == 0))
                    step(1'b1, 1'b0, 1'b0, 8'($urandom), v, h);
                rstn = !((v == rst_v) && ((h == rst_h) || (h == rst_h + 1)));
                step(rstn, 1'b1, ((v % 2) == 1) && ((h % 2) == 1), pattern(mode, v, h), v, h);

                if (!gaps && (mode != c_M_RAND) && (v == 1) && (h == 2 || h == 4)) begin
                    chk("dir_en",   32'(out_enable0), 32'd1);
                    chk("dir_pix",  32'(out_pixel0),  32'(first_strobe(mode, (h == 2) ? 0 : 1)));
                    chk("dir_hcnt", 32'(out_hcnt0),   32'(h - 1));
                    chk("dir_vcnt", 32'(out_vcnt0),   32'd1);
                end
                if (rst_v >= 0 && v == rst_v && h == rst_h) begin
                    chk("rst_vcnt", 32'(out_vcnt0),   32'd0);
                    chk("rst_hcnt", 32'(out_hcnt0),   32'd0);
                    chk("rst_en",   32'(out_enable0), 32'd0);
                    chk("rst_pix",  32'(out_pixel0),  32'd0);
                end
                if (rst_v >= 0 && v == rst_v && h == rst_h + 2) begin
                    chk("post_rst_vcnt", 32'(out_vcnt0), 32'd0);
                    chk("post_rst_hcnt", 32'(out_hcnt0), 32'd0);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            e_en[d] = 0; e_pix[d] = 0; s1v[d] = 0; s1p[d] = 0; primed[d] = 0;
            for (int v = 0; v < c_FH; v++)
                for (int h = 0; h < c_FW; h++)
                    img[d][v][h] = 0;
        end
        e_v = 0; e_h = 0; d1v = 0; d1h = 0;
        n_rst = 1'b0; in_enable0 = 1'b0; in_enable1 = 1'b0;
        in_pixel = '0; in_vcnt = '0; in_hcnt = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom), 1, 1);
        chk("reset_pix",  32'(out_pixel0),  32'd0);
        chk("reset_en",   32'(out_enable0), 32'd0);
        chk("reset_vcnt", 32'(out_vcnt1),   32'd0);

        frame(c_M_RAMP,  1'b0, -1, -1);   // ramp, first strobe = 5
        frame(c_M_FF,    1'b0, -1, -1);   // full-scale, no overflow
        frame(c_M_ZERO,  1'b0, -1, -1);
        frame(c_M_ROUND, 1'b0, -1, -1);   // rounding of 2/4 and 1/4
        frame(c_M_RAND,  1'b1, -1, -1);   // random data with stalls
        frame(c_M_RAND,  1'b0,  1,  3);   // reset inside row 1
        frame(c_M_RAND,  1'b1, -1, -1);
        frame(c_M_RAMP,  1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
